// File: rtl/sap_cpu_core.sv
// Multicycle accumulator CPU core: FETCH/DECODE/MEM/OUTW/HALT sequencer with
// valid/ready memory and output ports; widths are parameters.
module sap_cpu_core #(
    parameter int DATA_W = 8,
    parameter int OPC_W  = 4,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              flag_cy,
    output logic              flag_z,
    output logic              halted,
    output logic [ADDR_W-1:0] pc_dbg,
    output logic [DATA_W-1:0] acc_dbg
);

    if (DATA_W - OPC_W < ADDR_W) begin : g_bad_widths
        $error("sap_cpu_core: operand field narrower than ADDR_W");
    end

    localparam logic [OPC_W-1:0] OP_LDA = OPC_W'(1);
    localparam logic [OPC_W-1:0] OP_ADD = OPC_W'(2);
    localparam logic [OPC_W-1:0] OP_SUB = OPC_W'(3);
    localparam logic [OPC_W-1:0] OP_STA = OPC_W'(4);
    localparam logic [OPC_W-1:0] OP_LDI = OPC_W'(5);
    localparam logic [OPC_W-1:0] OP_JMP = OPC_W'(6);
    localparam logic [OPC_W-1:0] OP_JC  = OPC_W'(7);
    localparam logic [OPC_W-1:0] OP_JZ  = OPC_W'(8);
    localparam logic [OPC_W-1:0] OP_OUT = OPC_W'(14);
    localparam logic [OPC_W-1:0] OP_HLT = OPC_W'(15);

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_MEM, S_OUTW, S_HALT} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] out_q, out_d;
    logic              cy_q, cy_d, z_q, z_d;
    logic              run_q;

    logic [OPC_W-1:0]  op;
    logic [ADDR_W-1:0] opr;
    logic [DATA_W-1:0] opr_ext;
    logic [DATA_W:0]   add_sum, sub_sum;
    logic              ack;

    always_comb begin
        op      = ir_q[DATA_W-1 -: OPC_W];
        opr     = ir_q[ADDR_W-1:0];
        opr_ext = '0;
        opr_ext[ADDR_W-1:0] = opr;
        add_sum = {1'b0, a_q} + {1'b0, mem_rdata};
        sub_sum = {1'b0, a_q} + {1'b0, ~mem_rdata} + {{DATA_W{1'b0}}, 1'b1};

        // run_q keeps the request low in the first cycle after reset.
        mem_req   = run_q && (state_q == S_FETCH || state_q == S_MEM);
        mem_we    = (state_q == S_MEM) && (op == OP_STA);
        mem_addr  = (state_q == S_MEM) ? opr : pc_q;
        mem_wdata = a_q;
        ack       = mem_req && mem_ack;

        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        a_d     = a_q;
        out_d   = out_q;
        cy_d    = cy_q;
        z_d     = z_q;

        case (state_q)
            S_FETCH: if (ack) begin
                ir_d    = mem_rdata;
                pc_d    = pc_q + ADDR_W'(1);
                state_d = S_DECODE;
            end
            S_DECODE: begin
                state_d = S_FETCH;
                case (op)
                    OP_LDI: a_d = opr_ext;
                    OP_JMP: pc_d = opr;
                    OP_JC:  if (cy_q) pc_d = opr;
                    OP_JZ:  if (z_q)  pc_d = opr;
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: state_d = S_MEM;
                    OP_OUT: begin
                        out_d   = a_q;
                        state_d = S_OUTW;
                    end
                    OP_HLT: state_d = S_HALT;
                    default: ;
                endcase
            end
            S_MEM: if (ack) begin
                state_d = S_FETCH;
                case (op)
                    OP_LDA: a_d = mem_rdata;
                    OP_ADD: begin
                        {cy_d, a_d} = add_sum;
                        z_d = (add_sum[DATA_W-1:0] == '0);
                    end
                    OP_SUB: begin
                        {cy_d, a_d} = sub_sum;
                        z_d = (sub_sum[DATA_W-1:0] == '0);
                    end
                    default: ;
                endcase
            end
            S_OUTW: if (out_ready) state_d = S_FETCH;
            S_HALT: ;
            default: state_d = S_FETCH;
        endcase

        out_valid = (state_q == S_OUTW);
        halted    = (state_q == S_HALT);
        out_data  = out_q;
        flag_cy   = cy_q;
        flag_z    = z_q;
        pc_dbg    = pc_q;
        acc_dbg   = a_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            a_q     <= '0;
            out_q   <= '0;
            cy_q    <= 1'b0;
            z_q     <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            out_q   <= out_d;
            cy_q    <= cy_d;
            z_q     <= z_d;
            run_q   <= 1'b1;
        end
    end

endmodule
